pipe_skid_stage: RTL

Parametrised pipeline stage register for the processor datapath; the generalised successor to the fixed-field inter-stage buffers. It holds a control bundle and a data bundle of configurable width. A two-entry skid structure gives valid/ready back-pressure at full throughput, and a synchronous flush turns the stage into a bubble. Stage instances sit between Decode/Execute, Execute/Memory and Memory/Writeback. A hazard unit drives `out_ready` (stall) and `flush`.

---
 rtl/pipe_skid_stage.sv | 136 +++++++++++++
 1 files changed

// File: rtl/pipe_skid_stage.sv
// pipe_skid_stage
//   Inter-stage pipeline register with a two-entry skid buffer.
//   The skid buffer gives full-throughput valid/ready handshaking.
//   The "main" entry drives the outputs. The "skid" entry catches the one
//   instruction that is already in flight when downstream stalls.
//   Because of the skid entry, in_ready can be a pure register and still
//   lose nothing.
//   A synchronous flush turns the stage into a bubble.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   flush      synchronous squash of all held entries
//   in_valid   upstream presents an instruction
//   in_ready   stage can accept (registered, state-only)
//   in_ctrl    upstream control bundle  [CTRL_W]
//   in_data    upstream payload bundle  [DATA_W]
//   out_valid  stage holds a valid instruction
//   out_ready  downstream accepts this cycle (0 = stall)
//   out_ctrl   control bundle, forced to zero on a bubble
//   out_data   payload, holds its last value on a bubble
//   occupancy  number of held entries (0..2)
module pipe_skid_stage #(
    parameter int CTRL_W = 16,
    parameter int DATA_W = 56
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
);

    // The encoding equals the occupancy count, so occupancy is the state itself.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic              in_ready_q, in_ready_d;
    logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
    logic [DATA_W-1:0] main_data_q, main_data_d;
    logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
    logic [DATA_W-1:0] skid_data_q, skid_data_d;

    logic in_fire;
    logic out_fire;

    assign out_valid = (state_q != ST_EMPTY);
    assign in_fire   = in_valid & in_ready_q;
    assign out_fire  = out_valid & out_ready;

    always_comb begin
        state_d     = state_q;
        main_ctrl_d = main_ctrl_q;
        main_data_d = main_data_q;
        skid_ctrl_d = skid_ctrl_q;
        skid_data_d = skid_data_q;

        if (flush) begin
            // Flush wins over everything. An instruction arriving in the
            // same cycle is dropped. The payload registers keep their
            // contents, so out_data stays stable.
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (in_fire) begin
                        state_d     = ST_ONE;
                        main_ctrl_d = in_ctrl;
                        main_data_d = in_data;
                    end
                end
                ST_ONE: begin
                    if (in_fire && out_fire) begin
                        main_ctrl_d = in_ctrl;
                        main_data_d = in_data;
                    end else if (in_fire) begin
                        // Downstream stalled while a new instruction arrived.
                        // Park the new instruction in skid.
                        state_d     = ST_FULL;
                        skid_ctrl_d = in_ctrl;
                        skid_data_d = in_data;
                    end else if (out_fire) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    // in_ready is low in FULL, so only draining is possible.
                    if (out_fire) begin
                        state_d     = ST_ONE;
                        main_ctrl_d = skid_ctrl_q;
                        main_data_d = skid_data_q;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end

        in_ready_d = (state_d != ST_FULL);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_EMPTY;
            in_ready_q  <= 1'b1;
            main_ctrl_q <= '0;
            main_data_q <= '0;
            skid_ctrl_q <= '0;
            skid_data_q <= '0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            main_ctrl_q <= main_ctrl_d;
            main_data_q <= main_data_d;
            skid_ctrl_q <= skid_ctrl_d;
            skid_data_q <= skid_data_d;
        end
    end

    assign in_ready  = in_ready_q;
    // A bubble must never carry live control bits into later stages.
    assign out_ctrl  = out_valid ? main_ctrl_q : '0;
    assign out_data  = main_data_q;
    assign occupancy = state_q;

endmodule
